data_wbuf: RTL and testbench

- MMU-side responder for the core's data write port (DATA_WREN/DATA_WADDR/DATA_WDATA). It accepts full-word stores that the write stage has already merged.
- Stores are queued in a small FIFO and drained one at a time to an AXI4-Lite write master (AW/W/B).
- Provides backpressure (DATA_WBUSY) to the pipeline stall logic, plus sticky error and overflow status.

---
 rtl/data_wbuf_if.sv | 23 ++
 rtl/data_wbuf.sv | 154 +++++++++++++++
 tb/tb_data_wbuf.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/data_wbuf_if.sv
// AXI4-Lite write channel bundle (AW/W/B) between data_wbuf and the interconnect.
interface data_wbuf_if;
   logic [31:0] M_AWADDR;
   logic        M_AWVALID;
   logic        M_AWREADY;
   logic [31:0] M_WDATA;
   logic [3:0]  M_WSTRB;
   logic        M_WVALID;
   logic        M_WREADY;
   logic [1:0]  M_BRESP;
   logic        M_BVALID;
   logic        M_BREADY;

   modport master (
      output M_AWADDR, M_AWVALID, M_WDATA, M_WSTRB, M_WVALID, M_BREADY,
      input  M_AWREADY, M_WREADY, M_BRESP, M_BVALID
   );

   modport slave (
      input  M_AWADDR, M_AWVALID, M_WDATA, M_WSTRB, M_WVALID, M_BREADY,
      output M_AWREADY, M_WREADY, M_BRESP, M_BVALID
   );
endinterface

// File: rtl/data_wbuf.sv
// Data write buffer: queues merged stores and drains them one at a time over AXI4-Lite.
// Define DATA_WBUF_FWD_EN to build the store-to-load forwarding comparators.
module data_wbuf #(
   parameter int DEPTH = 4,
   parameter int AW    = 32
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          DATA_WREN,
   input  logic [AW-1:0] DATA_WADDR,
   input  logic [31:0]   DATA_WDATA,
   output logic          DATA_WBUSY,
   output logic          WBUF_EMPTY,
   output logic          WBUF_ERR,
   output logic          WBUF_OVF,
   data_wbuf_if.master   axi,
   input  logic [AW-1:0] FWD_RADDR,
   output logic          FWD_HIT,
   output logic [31:0]   FWD_RDATA
);
   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] PONE = (PW+1)'(1);

   typedef enum logic [1:0] {IDLE, ADDR, RESP} state_t;

   logic [AW-3:0] addr_mem [DEPTH];
   logic [31:0]   data_mem [DEPTH];
   logic [PW:0]   wptr, rptr;
   logic          full, empty, push, pop;

   state_t        state_q, state_d;
   logic          awv_q, awv_d, wv_q, wv_d, bready_q, bready_d;
   logic [AW-1:0] awaddr_q, awaddr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic          err_q, ovf_q;

   assign full  = (wptr[PW] != rptr[PW]) && (wptr[PW-1:0] == rptr[PW-1:0]);
   assign empty = (wptr == rptr);
   assign push  = DATA_WREN && !full;

   assign DATA_WBUSY = full;
   assign WBUF_EMPTY = empty && (state_q == IDLE);
   assign WBUF_ERR   = err_q;
   assign WBUF_OVF   = ovf_q;

   assign axi.M_AWADDR  = awaddr_q;
   assign axi.M_AWVALID = awv_q;
   assign axi.M_WDATA   = wdata_q;
   assign axi.M_WSTRB   = 4'b1111;
   assign axi.M_WVALID  = wv_q;
   assign axi.M_BREADY  = bready_q;

   always_ff @(posedge CLK) begin
      if (push) begin
         addr_mem[wptr[PW-1:0]] <= DATA_WADDR[AW-1:2];
         data_mem[wptr[PW-1:0]] <= DATA_WDATA;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         wptr     <= '0;
         rptr     <= '0;
         state_q  <= IDLE;
         awv_q    <= 1'b0;
         wv_q     <= 1'b0;
         bready_q <= 1'b0;
         awaddr_q <= '0;
         wdata_q  <= '0;
         err_q    <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         awv_q    <= awv_d;
         wv_q     <= wv_d;
         bready_q <= bready_d;
         awaddr_q <= awaddr_d;
         wdata_q  <= wdata_d;
         if (push) wptr <= wptr + PONE;
         if (pop) rptr <= rptr + PONE;
         if (DATA_WREN && full) ovf_q <= 1'b1;
         if (pop && axi.M_BRESP != 2'b00) err_q <= 1'b1;
      end
   end

   // Head stays queued until its B handshake so forwarding still sees it.
   always_comb begin
      state_d  = state_q;
      awv_d    = awv_q;
      wv_d     = wv_q;
      bready_d = bready_q;
      awaddr_d = awaddr_q;
      wdata_d  = wdata_q;
      pop      = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!empty) begin
               awaddr_d = {addr_mem[rptr[PW-1:0]], 2'b00};
               wdata_d  = data_mem[rptr[PW-1:0]];
               awv_d    = 1'b1;
               wv_d     = 1'b1;
               state_d  = ADDR;
            end
         end
         ADDR: begin
            awv_d = awv_q && !axi.M_AWREADY;
            wv_d  = wv_q && !axi.M_WREADY;
            if (!awv_d && !wv_d) begin
               bready_d = 1'b1;
               state_d  = RESP;
            end
         end
         RESP: begin
            if (axi.M_BVALID) begin
               pop      = 1'b1;
               bready_d = 1'b0;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   logic unused_lo;
   assign unused_lo = ^{DATA_WADDR[1:0], FWD_RADDR[1:0]};

`ifdef DATA_WBUF_FWD_EN
   logic [PW:0] cnt;
   assign cnt = wptr - rptr;

   // Walk oldest to youngest so the last match wins.
   always_comb begin
      logic [PW:0] kk;
      logic [PW:0] idx;
      FWD_HIT   = 1'b0;
      FWD_RDATA = '0;
      kk        = '0;
      idx       = '0;
      for (int k = 0; k < DEPTH; k++) begin
         kk  = (PW+1)'(k);
         idx = rptr + kk;
         if (kk < cnt && addr_mem[idx[PW-1:0]] == FWD_RADDR[AW-1:2]) begin
            FWD_HIT   = 1'b1;
            FWD_RDATA = data_mem[idx[PW-1:0]];
         end
      end
   end
`else
   logic unused_fwd;
   assign unused_fwd = ^FWD_RADDR;
   assign FWD_HIT    = 1'b0;
   assign FWD_RDATA  = '0;
`endif
endmodule

// File: tb/tb_data_wbuf.sv
// Scoreboard bench for data_wbuf: directed stores, AXI slave model, monitor on AW/W handshakes.
module tb_data_wbuf;
   logic        CLK = 1'b0;
   logic        RST;
   logic        DATA_WREN;
   logic [31:0] DATA_WADDR;
   logic [31:0] DATA_WDATA;
   logic        DATA_WBUSY;
   logic        WBUF_EMPTY;
   logic        WBUF_ERR;
   logic        WBUF_OVF;
   logic [31:0] FWD_RADDR;
   logic        FWD_HIT;
   logic [31:0] FWD_RDATA;

   data_wbuf_if bus ();

   data_wbuf #(.DEPTH(4), .AW(32)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .DATA_WREN  (DATA_WREN),
      .DATA_WADDR (DATA_WADDR),
      .DATA_WDATA (DATA_WDATA),
      .DATA_WBUSY (DATA_WBUSY),
      .WBUF_EMPTY (WBUF_EMPTY),
      .WBUF_ERR   (WBUF_ERR),
      .WBUF_OVF   (WBUF_OVF),
      .axi        (bus),
      .FWD_RADDR  (FWD_RADDR),
      .FWD_HIT    (FWD_HIT),
      .FWD_RDATA  (FWD_RDATA)
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;

   logic aw_en = 1'b0;
   logic w_en  = 1'b0;
   logic b_en  = 1'b1;
   logic [31:0] exp_aw [$];
   logic [31:0] exp_w  [$];
   logic [1:0]  resp_q [$];

   assign bus.M_AWREADY = aw_en;
   assign bus.M_WREADY  = w_en;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // B channel responder: BVALID one cycle after BREADY rises.
   initial begin
      logic set_b, clr_b;
      bus.M_BVALID = 1'b0;
      bus.M_BRESP  = 2'b00;
      forever begin
         @(negedge CLK);
         set_b = 1'b0;
         clr_b = 1'b0;
         if (bus.M_BVALID && bus.M_BREADY) clr_b = 1'b1;
         else if (bus.M_BREADY && !bus.M_BVALID && b_en) set_b = 1'b1;
         @(posedge CLK);
         #1;
         if (clr_b || RST) bus.M_BVALID = 1'b0;
         if (set_b) begin
            bus.M_BVALID = 1'b1;
            bus.M_BRESP  = (resp_q.size() != 0) ? resp_q.pop_front() : 2'b00;
         end
      end
   end

   // Monitor: compares every AW and W handshake against the expected queues.
   initial begin
      forever begin
         @(negedge CLK);
         if (!RST) begin
            if (bus.M_AWVALID && bus.M_AWREADY) begin
               if (exp_aw.size() == 0) chk("aw_unexpected", bus.M_AWADDR, 32'hFFFF_FFFF);
               else chk("aw_addr", bus.M_AWADDR, exp_aw.pop_front());
            end
            if (bus.M_WVALID && bus.M_WREADY) begin
               if (exp_w.size() == 0) chk("w_unexpected", bus.M_WDATA, 32'hFFFF_FFFF);
               else chk("w_data", bus.M_WDATA, exp_w.pop_front());
               chk("w_strb", {28'd0, bus.M_WSTRB}, 32'hF);
            end
         end
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] d, input bit accept);
      DATA_WREN  = 1'b1;
      DATA_WADDR = a;
      DATA_WDATA = d;
      if (accept) begin
         exp_aw.push_back({a[31:2], 2'b00});
         exp_w.push_back(d);
      end
      tick();
      DATA_WREN = 1'b0;
   endtask

   task automatic wait_empty(input string name, input int budget);
      int n;
      n = 0;
      while (!WBUF_EMPTY && n < budget) begin
         tick();
         n++;
      end
      chk(name, {31'd0, WBUF_EMPTY}, 32'd1);
   endtask

   initial begin
      int n;
      RST        = 1'b1;
      DATA_WREN  = 1'b0;
      DATA_WADDR = '0;
      DATA_WDATA = '0;
      FWD_RADDR  = '0;
      repeat (3) tick();
      chk("rst_busy", {31'd0, DATA_WBUSY}, 32'd0);
      chk("rst_empty", {31'd0, WBUF_EMPTY}, 32'd1);
      chk("rst_err", {31'd0, WBUF_ERR}, 32'd0);
      chk("rst_ovf", {31'd0, WBUF_OVF}, 32'd0);
      chk("rst_valids", {29'd0, bus.M_AWVALID, bus.M_WVALID, bus.M_BREADY}, 32'd0);
      chk("rst_awaddr", bus.M_AWADDR, 32'd0);
      chk("rst_wdata", bus.M_WDATA, 32'd0);
      chk("rst_fwd", {31'd0, FWD_HIT} | FWD_RDATA, 32'd0);
      RST = 1'b0;
      tick();

      // single store
      aw_en = 1'b1;
      w_en  = 1'b1;
      store(32'h0000_1003, 32'hDEAD_BEEF, 1'b1);
      chk("single_not_empty", {31'd0, WBUF_EMPTY}, 32'd0);
      tick();
      chk("single_awvalid", {31'd0, bus.M_AWVALID}, 32'd1);
      chk("single_awaddr", bus.M_AWADDR, 32'h0000_1000);
      wait_empty("single_drain", 20);

      // fill and overflow
      aw_en = 1'b0;
      w_en  = 1'b0;
      store(32'h100, 32'hA0, 1'b1);
      store(32'h104, 32'hA1, 1'b1);
      store(32'h108, 32'hA2, 1'b1);
      chk("fill_not_busy3", {31'd0, DATA_WBUSY}, 32'd0);
      store(32'h10C, 32'hA3, 1'b1);
      chk("fill_busy", {31'd0, DATA_WBUSY}, 32'd1);
      chk("fill_ovf_clear", {31'd0, WBUF_OVF}, 32'd0);
      store(32'h110, 32'hA4, 1'b0);
      chk("fill_ovf_set", {31'd0, WBUF_OVF}, 32'd1);
      chk("fill_still_busy", {31'd0, DATA_WBUSY}, 32'd1);
      aw_en = 1'b1;
      w_en  = 1'b1;
      wait_empty("fill_drain", 60);
      chk("fill_aw_consumed", exp_aw.size(), 32'd0);
      chk("fill_ovf_sticky", {31'd0, WBUF_OVF}, 32'd1);

      // split handshake: W in cycle 1, AW in cycle 3
      aw_en = 1'b0;
      w_en  = 1'b0;
      store(32'h300, 32'h5151_5151, 1'b1);
      tick();
      chk("split_c0", {30'd0, bus.M_AWVALID, bus.M_WVALID}, 32'd3);
      w_en = 1'b1;
      tick();
      w_en = 1'b0;
      chk("split_c1", {30'd0, bus.M_AWVALID, bus.M_WVALID}, 32'd2);
      tick();
      chk("split_c2_bready", {31'd0, bus.M_BREADY}, 32'd0);
      aw_en = 1'b1;
      tick();
      aw_en = 1'b0;
      chk("split_c3", {30'd0, bus.M_AWVALID, bus.M_WVALID}, 32'd0);
      chk("split_c4_bready", {31'd0, bus.M_BREADY}, 32'd1);
      wait_empty("split_drain", 20);

      // error response on first of two stores
      aw_en = 1'b1;
      w_en  = 1'b1;
      resp_q.push_back(2'b10);
      resp_q.push_back(2'b00);
      chk("err_before", {31'd0, WBUF_ERR}, 32'd0);
      store(32'h400, 32'hE0, 1'b1);
      store(32'h404, 32'hE1, 1'b1);
      wait_empty("err_drain", 40);
      chk("err_set", {31'd0, WBUF_ERR}, 32'd1);
      chk("err_w_consumed", exp_w.size(), 32'd0);
      store(32'h408, 32'hE2, 1'b1);
      wait_empty("err_drain2", 20);
      chk("err_sticky", {31'd0, WBUF_ERR}, 32'd1);

      // forwarding
      aw_en = 1'b0;
      w_en  = 1'b0;
      store(32'h200, 32'h11, 1'b1);
      store(32'h200, 32'h22, 1'b1);
      FWD_RADDR = 32'h202;
      #1;
`ifdef DATA_WBUF_FWD_EN
      chk("fwd_hit", {31'd0, FWD_HIT}, 32'd1);
      chk("fwd_data", FWD_RDATA, 32'h22);
`else
      chk("fwd_off_hit", {31'd0, FWD_HIT}, 32'd0);
      chk("fwd_off_data", FWD_RDATA, 32'd0);
`endif
      FWD_RADDR = 32'h204;
      #1;
      chk("fwd_miss", {31'd0, FWD_HIT}, 32'd0);
      aw_en = 1'b1;
      w_en  = 1'b1;
      wait_empty("fwd_drain", 40);

      // reset while waiting on B with two entries queued
      b_en = 1'b0;
      store(32'h500, 32'hC0, 1'b1);
      store(32'h504, 32'hC1, 1'b1);
      n = 0;
      while (!bus.M_BREADY && n < 20) begin
         tick();
         n++;
      end
      chk("resp_bready", {31'd0, bus.M_BREADY}, 32'd1);
      RST = 1'b1;
      tick();
      exp_aw.delete();
      exp_w.delete();
      chk("rst_resp_empty", {31'd0, WBUF_EMPTY}, 32'd1);
      chk("rst_resp_valids", {29'd0, bus.M_AWVALID, bus.M_WVALID, bus.M_BREADY}, 32'd0);
      chk("rst_resp_sticky", {30'd0, WBUF_ERR, WBUF_OVF}, 32'd0);
      chk("rst_resp_busy", {31'd0, DATA_WBUSY}, 32'd0);
      RST  = 1'b0;
      b_en = 1'b1;
      repeat (5) tick();
      chk("post_rst_idle", {30'd0, bus.M_AWVALID, WBUF_EMPTY}, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
